// File: rtl/rtc_set_ctrl_if.sv
// Button, time and load/display bundle between the RTC set controller and its
// surroundings. The counter-chain side drives master, the controller is slave.
interface rtc_set_ctrl_if;
   logic        btn_mode;
   logic        btn_inc;
   logic        btn_dec;
   logic [23:0] cur_time;
   logic        tick;
   logic        load;
   logic [23:0] ld_time;
   logic [1:0]  mode;
   logic [5:0]  blank;

   modport master (
      output btn_mode,
      output btn_inc,
      output btn_dec,
      output cur_time,
      input  tick,
      input  load,
      input  ld_time,
      input  mode,
      input  blank
   );

   modport slave (
      input  btn_mode,
      input  btn_inc,
      input  btn_dec,
      input  cur_time,
      output tick,
      output load,
      output ld_time,
      output mode,
      output blank
   );
endinterface

// File: rtl/rtc_set_ctrl.sv
// RTC sequencing/setting controller: 1 Hz tick, mode/inc/dec edit FSM, counter load strobe.
// Define RTC_SET_BLINK_EN to build the edited-field blink mask on blank.
module rtc_set_ctrl #(
   parameter int unsigned TICK_DIV = 50000000
) (
   input  logic          i_clk,
   input  logic          i_rst,
   rtc_set_ctrl_if.slave io_rtc
);
   localparam int unsigned    CW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0]  PRESC_LAST = CW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      StRun    = 2'd0,
      StSetHr  = 2'd1,
      StSetMin = 2'd2,
      StSetSec = 2'd3
   } state_t;

   state_t        r_state;
   logic [2:0]    r_btn_q;
   logic [7:0]    r_hr;
   logic [7:0]    r_min;
   logic [7:0]    r_sec;
   logic [CW-1:0] r_presc;
   logic          r_tick;
   logic          r_load;

   logic          w_mode_edge;
   logic          w_inc_edge;
   logic          w_dec_edge;
   logic          w_one_edit;
   logic          w_load_nxt;
   logic [CW-1:0] w_presc_nxt;
   state_t        w_state_nxt;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
      if (v == max) begin
         return 8'h00;
      end else if (v[3:0] == 4'd9) begin
         return {v[7:4] + 4'd1, 4'd0};
      end else begin
         return {v[7:4], v[3:0] + 4'd1};
      end
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
      if (v == 8'h00) begin
         return max;
      end else if (v[3:0] == 4'd0) begin
         return {v[7:4] - 4'd1, 4'd9};
      end else begin
         return {v[7:4], v[3:0] - 4'd1};
      end
   endfunction

   // Packed BCD compares numerically once the low digit is known to be valid.
   function automatic logic [7:0] san_hr(input logic [7:0] v);
      if ((v[3:0] > 4'd9) || (v > 8'h23)) begin
         return 8'h00;
      end
      return v;
   endfunction

   function automatic logic [7:0] san_ms(input logic [7:0] v);
      if ((v[7:4] > 4'd5) || (v[3:0] > 4'd9)) begin
         return 8'h00;
      end
      return v;
   endfunction

   assign w_mode_edge = io_rtc.btn_mode & ~r_btn_q[2];
   assign w_inc_edge  = io_rtc.btn_inc  & ~r_btn_q[1];
   assign w_dec_edge  = io_rtc.btn_dec  & ~r_btn_q[0];

   // Mode edge takes priority; simultaneous inc+dec cancel out.
   assign w_one_edit  = (w_inc_edge ^ w_dec_edge) & ~w_mode_edge & (r_state != StRun);
   assign w_load_nxt  = w_mode_edge ? (r_state == StSetSec) : w_one_edit;
   assign w_state_nxt = w_mode_edge ? state_t'(r_state + 2'd1) : r_state;

   assign w_presc_nxt = (w_load_nxt || (r_presc == PRESC_LAST)) ? '0 : r_presc + 1'b1;

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state <= StRun;
         r_btn_q <= {io_rtc.btn_mode, io_rtc.btn_inc, io_rtc.btn_dec};
         r_hr    <= 8'h00;
         r_min   <= 8'h00;
         r_sec   <= 8'h00;
         r_presc <= '0;
         r_tick  <= 1'b0;
         r_load  <= 1'b0;
      end else begin
         r_btn_q <= {io_rtc.btn_mode, io_rtc.btn_inc, io_rtc.btn_dec};
         r_state <= w_state_nxt;
         r_presc <= w_presc_nxt;
         r_load  <= w_load_nxt;
         r_tick  <= (r_state == StRun) && !w_mode_edge && (r_presc == PRESC_LAST);
         if (w_mode_edge && (r_state == StRun)) begin
            r_hr  <= san_hr(io_rtc.cur_time[23:16]);
            r_min <= san_ms(io_rtc.cur_time[15:8]);
            r_sec <= san_ms(io_rtc.cur_time[7:0]);
         end else if (w_one_edit) begin
            unique case (r_state)
               StSetHr:  r_hr  <= w_inc_edge ? bcd_inc(r_hr, 8'h23)  : bcd_dec(r_hr, 8'h23);
               StSetMin: r_min <= w_inc_edge ? bcd_inc(r_min, 8'h59) : bcd_dec(r_min, 8'h59);
               StSetSec: r_sec <= 8'h00;
               default:  ;
            endcase
         end
      end
   end

`ifdef RTC_SET_BLINK_EN
   localparam logic [CW-1:0] PRESC_HALF = CW'(TICK_DIV / 2);

   logic       w_phase_nxt;
   logic [5:0] r_blank;

   // Built from next-cycle state/prescaler so the registered mask lines up with them.
   assign w_phase_nxt = (w_presc_nxt >= PRESC_HALF);

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_blank <= 6'b000000;
      end else begin
         case (w_state_nxt)
            StSetHr:  r_blank <= {{2{w_phase_nxt}}, 4'b0000};
            StSetMin: r_blank <= {2'b00, {2{w_phase_nxt}}, 2'b00};
            StSetSec: r_blank <= {4'b0000, {2{w_phase_nxt}}};
            default:  r_blank <= 6'b000000;
         endcase
      end
   end

   assign io_rtc.blank = r_blank;
`else
   assign io_rtc.blank = 6'b000000;
`endif

   assign io_rtc.tick    = r_tick;
   assign io_rtc.load    = r_load;
   assign io_rtc.ld_time = {r_hr, r_min, r_sec};
   assign io_rtc.mode    = r_state;
endmodule
